// File: rtl/cskip_sub32_pipe_if.sv
// Operand/result handshake bundle for the pipelined carry-skip subtractor.
interface cskip_sub32_pipe_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (output in_valid, a, b, bin, out_ready,
                  input  in_ready, out_valid, diff, bout, ovf);
  modport slave  (input  in_valid, a, b, bin, out_ready,
                  output in_ready, out_valid, diff, bout, ovf);
endinterface

// File: rtl/cskip_sub32_pipe.sv
// Two-stage a - b - bin subtractor: low half in S1, high half in S2, each half a
// chain of BLK-bit lookahead blocks with block-skip carry.
module cskip_sub32_pipe #(
  parameter int WIDTH = 32,
  parameter int BLK   = 4
) (
  input logic               clk,
  input logic               rst_n,
  cskip_sub32_pipe_if.slave bus
);
  localparam int H  = WIDTH / 2;
  localparam int NB = H / BLK;

  // Returns {block carry-out, block sum}; carry-out skips straight from cin
  // when every bit propagates, otherwise it is the block's own generate.
  function automatic logic [BLK:0] cla_blk(input logic [BLK-1:0] x, y, input logic ci);
    logic [BLK-1:0] g, p;
    logic [BLK:0]   c, gc;
    g = x & y;
    p = x ^ y;
    c[0]  = ci;
    gc[0] = 1'b0;
    for (int i = 0; i < BLK; i++) begin
      c[i+1]  = g[i] | (p[i] & c[i]);
      gc[i+1] = g[i] | (p[i] & gc[i]);
    end
    return {(&p) ? ci : gc[BLK], p ^ c[BLK-1:0]};
  endfunction

  logic [2:1]       vld_pipe;
  logic             s1_adv, s2_adv;
  logic [WIDTH-1:0] bx;
  logic [H-1:0]     lo_s, hi_s;
  logic             lo_c, hi_c;
  logic [H-1:0]     s1_dlo, s1_ahi, s1_bxhi;
  logic             s1_cmid;

  assign bx            = ~bus.b;
  assign s2_adv        = !vld_pipe[2] || bus.out_ready;
  assign s1_adv        = !vld_pipe[1] || s2_adv;
  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = vld_pipe[2];

  // Low half: carry-in is the inverted borrow.
  for (genvar k = 0; k < NB; k++) begin : g_lo
    logic           ci;
    logic [BLK:0]   r;
    if (k == 0) begin : g_c0
      assign ci = ~bus.bin;
    end else begin : g_cn
      assign ci = g_lo[k-1].r[BLK];
    end
    assign r                   = cla_blk(bus.a[k*BLK +: BLK], bx[k*BLK +: BLK], ci);
    assign lo_s[k*BLK +: BLK]  = r[BLK-1:0];
  end
  assign lo_c = g_lo[NB-1].r[BLK];

  for (genvar k = 0; k < NB; k++) begin : g_hi
    logic           ci;
    logic [BLK:0]   r;
    if (k == 0) begin : g_c0
      assign ci = s1_cmid;
    end else begin : g_cn
      assign ci = g_hi[k-1].r[BLK];
    end
    assign r                   = cla_blk(s1_ahi[k*BLK +: BLK], s1_bxhi[k*BLK +: BLK], ci);
    assign hi_s[k*BLK +: BLK]  = r[BLK-1:0];
  end
  assign hi_c = g_hi[NB-1].r[BLK];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      if (s1_adv) vld_pipe[1] <= bus.in_valid;
      if (s2_adv) vld_pipe[2] <= vld_pipe[1];
    end
  end

  // Data only moves with a valid beat, so stale registers never pick up X.
  always_ff @(posedge clk) begin
    if (s1_adv && bus.in_valid) begin
      s1_dlo  <= lo_s;
      s1_cmid <= lo_c;
      s1_ahi  <= bus.a[WIDTH-1:H];
      s1_bxhi <= bx[WIDTH-1:H];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.diff <= '0;
      bus.bout <= 1'b0;
      bus.ovf  <= 1'b0;
    end else if (s2_adv && vld_pipe[1]) begin
      bus.diff <= {hi_s, s1_dlo};
      bus.bout <= ~hi_c;
      bus.ovf  <= (s1_ahi[H-1] ^ ~s1_bxhi[H-1]) & (hi_s[H-1] ^ s1_ahi[H-1]);
    end
  end
endmodule
